binary_mul_pipe: RTL and testbench
==================================

// Module: binary_mul_pipe
// PURPOSE
//  Parametrised, pipelined array multiplier that can run in signed or unsigned mode.
//  It generalises the fixed 6x6 signed array multiplier:
//   - operand widths are configurable;
//   - the product is full width (W_A+W_B bits, never truncated);
//   - signed/unsigned mode is selected per transaction;
//   - pipeline registers are inserted between partial-product rows;
//   - a valid/ready handshake supports backpressure.
//  It sits between operand producers and accumulator/MAC logic in the datapath.
// PARAMETERS
//  W_A            6  multiplicand width (>=2)
//  W_B            6  multiplier width (>=2)
//  ROWS_PER_STAGE 2  partial-product rows combined between pipeline registers (1..W_B)
//  Derived: N_ROW_STG = ceil(W_B/ROWS_PER_STAGE); LATENCY = N_ROW_STG + 1
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  en         in   1        global enable; 0 freezes every pipeline register
//  in_valid   in   1        operands valid
//  in_ready   out  1        block accepts operands this cycle
//  in_signed  in   1        1: A and B are two's complement; 0: both unsigned
//  A          in   W_A      multiplicand
//  B          in   W_B      multiplier
//  out_valid  out  1        P holds a valid product
//  out_ready  in   1        downstream accepts P
//  P          out  W_A+W_B  product; signed or unsigned according to that transaction's in_signed
// BEHAVIOUR
//  - Reset (asynchronous, rst_n=0): all stage valid bits, out_valid and P are cleared to 0.
//    Any transaction in flight is discarded; nothing is emitted after reset is released.
//  - Advance condition: adv = en & (~out_valid | out_ready).
//    The whole pipeline shifts together when adv=1; bubbles are not collapsed.
//  - in_ready = adv. A transfer happens when in_valid & in_ready.
//  - Output transfer: out_valid & out_ready. P and out_valid stay stable while out_ready=0.
//  - Latency: an accepted operand pair appears on P exactly LATENCY advancing cycles later.
//    With defaults and no stall, LATENCY = 4 cycles. Throughput is 1 per cycle.
//  - Each stage carries a valid bit, the in_signed flag, A (sign- or zero-extended to
//    W_A+W_B bits) and the remaining bits of B.
//  - Rows: row i adds A&B[i], shifted by i, into a carry-save (sum, carry) pair.
//    The extension bits come from A's extension.
//  - Signed row: in signed mode, row W_B-1 adds (-A)&B[W_B-1] (the two's-complement weight
//    of the multiplier MSB). In unsigned mode it adds A&B[W_B-1] like every other row.
//  - Final stage: a carry-propagate adder resolves sum+carry modulo 2^(W_A+W_B) into P.
//  - Boundaries:
//    - Signed min*min (-2^(W_A-1) * -2^(W_B-1)) yields +2^(W_A+W_B-2). It must fit with no
//      overflow.
//    - In signed mode, -A of A=-2^(W_A-1) is formed on the extended width, so it never wraps.
//    - en=0 overrides out_ready: no advance, in_ready=0, and outputs hold.
//    - in_valid=1 with in_ready=0: the operands are not captured, and the producer must hold them.
//    - Simultaneous output drain and input accept in one cycle is allowed; this keeps full throughput.
// STRUCTURE
//  - Shared package mul_pkg holds:
//    - the function clog2/ceil-div used for N_ROW_STG;
//    - the localparam P_W = W_A+W_B computation helper;
//    - the typedef of the stage payload struct {valid, is_signed, sum, carry, a_ext, b_rem}.
//  - One sub-module, mul_csa_row: combinational carry-save row with inputs (sum, carry, a_ext,
//    b_bit, neg, shift) and outputs (sum', carry'). It is instantiated W_B times via generate.
//    A register slice is inserted after every ROWS_PER_STAGE rows.
//  - The top level holds the stage registers, the adv/handshake logic and the final CPA
//    (plain + operator).
// TESTING (defaults W_A=W_B=6, ROWS_PER_STAGE=2)
//  1. Signed min*min: A=-32, B=-32, in_signed=1, out_ready=1.
//     Expect P=12'h400 (+1024) exactly 4 cycles after the accept.
//  2. Signed mixed / unsigned max:
//     - A=31, B=-32 signed: expect P=-992 (12'hC20).
//     - A=63, B=63 unsigned: expect P=3969 (12'hF81).
//     - Issued back to back, the results appear on consecutive cycles.
//  3. Streaming: 64 random pairs with random in_signed each cycle and out_ready=1.
//     Expect one result per cycle, in order, matching a golden model.
//  4. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
//     Expect in_ready=0 while out_valid=1, P stable, and no loss or duplication after release.
//  5. en=0 for 3 cycles mid-stream: all state is frozen and in_ready=0.
//     After en returns to 1, the results resume, unchanged and in order.
//  6. Reset mid-operation: assert rst_n=0 with 3 transactions in flight.
//     Expect out_valid=0 and P=0 immediately.
//     After release, none of the old results appear; the next result comes 4 cycles after a new accept.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined array multiplier: sizing helpers and the
// payload carried by every pipeline stage.
package mul_pkg;

    // Internal datapath widths; a configuration must satisfy W_A+W_B <= P_W_MAX, W_B <= B_W_MAX.
    localparam int P_W_MAX = 64;
    localparam int B_W_MAX = 32;
    localparam int SH_W    = 6;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 32'sd1) / den;
    endfunction

    function automatic int prod_width(input int wa, input int wb);
        return wa + wb;
    endfunction

    typedef struct packed {
        logic               valid;
        logic               is_signed;
        logic [P_W_MAX-1:0] sum;
        logic [P_W_MAX-1:0] carry;
        logic [P_W_MAX-1:0] a_ext;
        logic [B_W_MAX-1:0] b_rem;
    } mul_stage_t;

endpackage

// File: rtl/mul_csa_row.sv
// One partial-product row folded into a carry-save (sum, carry) pair.
// With neg set the row contributes the negative weight of the multiplier MSB.
module mul_csa_row
    import mul_pkg::*;
(
    input  logic [P_W_MAX-1:0] sum,
    input  logic [P_W_MAX-1:0] carry,
    input  logic [P_W_MAX-1:0] a_ext,
    input  logic               b_bit,
    input  logic               neg,
    input  logic [SH_W-1:0]    shift,
    output logic [P_W_MAX-1:0] sum_nxt,
    output logic [P_W_MAX-1:0] carry_nxt
);

    logic [P_W_MAX-1:0] pp_s;

    // Partial product: +/-A aligned to this row's weight, or zero when the B bit is clear.
    always_comb begin
        pp_s = {P_W_MAX{1'b0}};
        if (b_bit) begin
            if (neg) begin
                pp_s = (-a_ext) << shift;
            end else begin
                pp_s = a_ext << shift;
            end
        end else begin
            pp_s = {P_W_MAX{1'b0}};
        end
    end

    // 3:2 compression; the carry moves up one weight and wraps at the datapath width.
    assign sum_nxt   = sum ^ carry ^ pp_s;
    assign carry_nxt = ((sum & carry) | (sum & pp_s) | (carry & pp_s)) << 1;

endmodule

// File: rtl/binary_mul_pipe.sv
// Pipelined signed/unsigned array multiplier with a full-width product and a
// valid/ready handshake; the whole pipe advances together so bubbles are kept.
module binary_mul_pipe
    import mul_pkg::*;
#(
    parameter int W_A            = 6,
    parameter int W_B            = 6,
    parameter int ROWS_PER_STAGE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [W_A-1:0]       A,
    input  logic [W_B-1:0]       B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W_A+W_B-1:0]   P
);

    localparam int N_ROW_STG = ceil_div(W_B, ROWS_PER_STAGE);
    localparam int P_W       = prod_width(W_A, W_B);

    mul_stage_t         st_r  [N_ROW_STG];
    mul_stage_t         grp_s [N_ROW_STG];
    mul_stage_t         in_stage_s;
    logic               adv_s;
    logic               out_valid_r;
    logic [P_W-1:0]     p_r;
    logic [P_W-1:0]     cpa_s;

    assign adv_s     = en & (~out_valid_r | out_ready);
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign P         = p_r;

    // Stage-0 payload: A extended per the transaction's mode, B zero-extended, empty CSA pair.
    always_comb begin
        in_stage_s           = '0;
        in_stage_s.valid     = in_valid;
        in_stage_s.is_signed = in_signed;
        if (in_signed) begin
            in_stage_s.a_ext = P_W_MAX'($signed(A));
        end else begin
            in_stage_s.a_ext = P_W_MAX'(A);
        end
        in_stage_s.b_rem = B_W_MAX'(B);
    end

    // Row group g consumes the low ROWS_PER_STAGE bits of b_rem held in stage g.
    for (genvar g = 0; g < N_ROW_STG; g++) begin : g_stage
        logic [P_W_MAX-1:0] sum_s   [ROWS_PER_STAGE+1];
        logic [P_W_MAX-1:0] carry_s [ROWS_PER_STAGE+1];

        assign sum_s[0]   = st_r[g].sum;
        assign carry_s[0] = st_r[g].carry;

        for (genvar j = 0; j < ROWS_PER_STAGE; j++) begin : g_row
            localparam int ROW = g * ROWS_PER_STAGE + j;
            if (ROW < W_B) begin : g_act
                logic neg_s;
                if (ROW == W_B - 1) begin : g_msb
                    assign neg_s = st_r[g].is_signed;
                end else begin : g_lsb
                    assign neg_s = 1'b0;
                end
                mul_csa_row u_row (
                    .sum       (sum_s[j]),
                    .carry     (carry_s[j]),
                    .a_ext     (st_r[g].a_ext),
                    .b_bit     (st_r[g].b_rem[j]),
                    .neg       (neg_s),
                    .shift     (SH_W'(ROW)),
                    .sum_nxt   (sum_s[j+1]),
                    .carry_nxt (carry_s[j+1])
                );
            end else begin : g_pass
                assign sum_s[j+1]   = sum_s[j];
                assign carry_s[j+1] = carry_s[j];
            end
        end

        assign grp_s[g] = {st_r[g].valid, st_r[g].is_signed,
                           sum_s[ROWS_PER_STAGE], carry_s[ROWS_PER_STAGE],
                           st_r[g].a_ext, st_r[g].b_rem >> ROWS_PER_STAGE};
    end

    // The last group is still combinational here, so the CPA sits in the output stage.
    assign cpa_s = P_W'(grp_s[N_ROW_STG-1].sum + grp_s[N_ROW_STG-1].carry);

    // Stage registers: all stages shift together whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ROW_STG; k++) begin
                st_r[k] <= '0;
            end
        end else if (adv_s) begin
            st_r[0] <= in_stage_s;
            for (int k = 1; k < N_ROW_STG; k++) begin
                st_r[k] <= grp_s[k-1];
            end
        end else begin
            st_r <= st_r;
        end
    end

    // Output register: holds P and out_valid whenever the pipe does not advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            p_r         <= {P_W{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= grp_s[N_ROW_STG-1].valid;
            p_r         <= cpa_s;
        end else begin
            out_valid_r <= out_valid_r;
            p_r         <= p_r;
        end
    end

endmodule

// File: tb/tb_binary_mul_pipe.sv
// Randomised and directed bench for binary_mul_pipe at the default 6x6 configuration;
// products are predicted with plain integer arithmetic and matched in order.
module tb_binary_mul_pipe;

    localparam int W_A = 6;
    localparam int W_B = 6;
    localparam int P_W = 12;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [W_A-1:0] a = '0;
    logic [W_B-1:0] b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [P_W-1:0] p;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    logic           chk_lat = 1'b0;
    logic [P_W-1:0] exp_q[$];
    int             lat_q[$];
    logic           accepted = 1'b0;
    logic           drained = 1'b0;
    logic [P_W-1:0] drained_p = '0;
    logic           have_prev = 1'b0;
    logic           prev_adv = 1'b0;
    logic           prev_ov = 1'b0;
    logic [P_W-1:0] prev_p = '0;

    always #5 clk = ~clk;

    binary_mul_pipe #(.W_A(W_A), .W_B(W_B), .ROWS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference product from the integer values of the operands.
    function automatic logic [P_W-1:0] ref_mul(input logic [W_A-1:0] x, input logic [W_B-1:0] y,
                                               input logic s);
        longint     xv;
        longint     yv;
        logic [63:0] pb;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[W_A-1]) xv = xv - (64'sd1 <<< W_A);
        if (s && y[W_B-1]) yv = yv - (64'sd1 <<< W_B);
        pb = 64'(xv * yv);
        return pb[P_W-1:0];
    endfunction

    // One clock: sample just after the falling edge, score transfers, move to the next falling edge.
    task automatic tick();
        logic [P_W-1:0] e;
        int             t;
        #1;
        accepted = 1'b0;
        drained  = 1'b0;
        if (rst_n) begin
            check_eq("in_ready", 64'(in_ready), 64'(en & (~out_valid | out_ready)));
            if (have_prev && !prev_adv) begin
                check_eq("hold_valid", 64'(out_valid), 64'(prev_ov));
                check_eq("hold_p", 64'(p), 64'(prev_p));
            end
            if (out_valid && out_ready && en) begin
                drained   = 1'b1;
                drained_p = p;
                if (exp_q.size() == 0) begin
                    check_eq("extra_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = lat_q.pop_front();
                    check_eq("product", 64'(p), 64'(e));
                    if (chk_lat) check_eq("latency", 64'(cyc - t), 64'd4);
                end
            end
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                exp_q.push_back(ref_mul(a, b, in_signed));
                lat_q.push_back(cyc);
            end
            prev_adv  = en & (~out_valid | out_ready);
            prev_ov   = out_valid;
            prev_p    = p;
            have_prev = 1'b1;
        end else begin
            have_prev = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue(input logic [W_A-1:0] x, input logic [W_B-1:0] y, input logic s);
        a = x;
        b = y;
        in_signed = s;
        in_valid = 1'b1;
        tick();
        check_eq("issue_accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output logic [P_W-1:0] pv, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!drained && n < 20);
        if (!drained) check_eq("drain_timeout", 64'd0, 64'd1);
        pv = drained_p;
    endtask

    // Random operands every accept; kind 1 drops out_ready, kind 2 drops en for a window.
    task automatic stream(input int n_acc, input int stall_at, input int stall_len, input int kind);
        int   got = 0;
        int   k = 0;
        logic need = 1'b1;
        while (got < n_acc && k < 2000) begin
            if (need) begin
                a = W_A'($urandom);
                b = W_B'($urandom);
                in_signed = 1'($urandom_range(0, 1));
                need = 1'b0;
            end
            in_valid = 1'b1;
            en = 1'b1;
            out_ready = 1'b1;
            if (k >= stall_at && k < stall_at + stall_len) begin
                if (kind == 1) out_ready = 1'b0;
                else if (kind == 2) en = 1'b0;
            end
            tick();
            k++;
            if (accepted) begin
                got++;
                need = 1'b1;
            end
        end
        if (got < n_acc) check_eq("stream_bound", 64'(got), 64'(n_acc));
        in_valid = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        logic [P_W-1:0] pv;
        int             n;

        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_p", 64'(p), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        tick();

        // Signed min*min must reach +2^10 with no overflow.
        chk_lat = 1'b1;
        issue(6'h20, 6'h20, 1'b1);
        wait_drain(pv, n);
        check_eq("minmin_p", 64'(pv), 64'h400);
        check_eq("minmin_lat", 64'(n), 64'd4);

        // Signed mixed then unsigned max, issued back to back.
        issue(6'd31, 6'h20, 1'b1);
        issue(6'd63, 6'd63, 1'b0);
        wait_drain(pv, n);
        check_eq("mixed_p", 64'(pv), 64'hC20);
        check_eq("mixed_lat", 64'(n), 64'd3);
        wait_drain(pv, n);
        check_eq("umax_p", 64'(pv), 64'hF81);
        check_eq("umax_gap", 64'(n), 64'd1);

        stream(64, 0, 0, 0);

        chk_lat = 1'b0;
        stream(20, 8, 5, 1);
        stream(20, 6, 3, 2);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            a = W_A'($urandom);
            b = W_B'($urandom);
            in_signed = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_p", 64'(p), 64'd0);
        exp_q.delete();
        lat_q.delete();
        have_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("post_rst_idle", 64'(out_valid), 64'd0);
        end
        chk_lat = 1'b1;
        issue(6'h2B, 6'h11, 1'b1);
        wait_drain(pv, n);
        check_eq("post_rst_p", 64'(pv), 64'(ref_mul(6'h2B, 6'h11, 1'b1)));
        check_eq("post_rst_lat", 64'(n), 64'd4);

        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
